// File: rtl/seg_scan_reader.sv
// Frame-snapshot display scanner: latches a bank of 7-bit segment codes once per
// frame and time-multiplexes them onto one segment bus with blanking between digits.
module seg_scan_reader #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [7*NUM_DIGITS-1:0] din,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_start,
    output logic [2:0]              cur_digit
);
    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [2:0]    LAST_DIGIT = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              cur_q, cur_d;
    logic [7*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    fs_q, fs_d;
    logic [6:0]              snap_arr [8];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        snap_d  = snap_q;
        fs_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    cur_d   = 3'd0;
                    snap_d  = din;
                    fs_d    = 1'b1;
                end
            end
            S_BLANK: begin
                if (!en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    cur_d   = 3'd0;
                end else if (cnt_q == BLANK_LAST) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRIVE: begin
                if (!en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    cur_d   = 3'd0;
                end else if (cnt_q == DWELL_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    // Wrapping past the last digit starts a new frame with a fresh snapshot.
                    if (cur_q == LAST_DIGIT) begin
                        cur_d  = 3'd0;
                        snap_d = din;
                        fs_d   = 1'b1;
                    end else begin
                        cur_d = cur_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                cur_d   = 3'd0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dig
            if (gi < NUM_DIGITS) begin : g_used
                assign snap_arr[gi] = snap_d[7*gi +: 7];
            end else begin : g_pad
                assign snap_arr[gi] = 7'd0;
            end
        end
    endgenerate

    // Output registers are loaded from the state being entered, so they track state_d.
    always_comb begin
        seg_d = 7'd0;
        dig_d = '0;
        if (state_d == S_DRIVE) begin
            seg_d = snap_arr[cur_d];
            dig_d = NUM_DIGITS'(1) << cur_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cur_q   <= 3'd0;
            snap_q  <= '0;
            seg_q   <= 7'd0;
            dig_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            fs_q    <= fs_d;
        end
    end

    assign seg_out     = seg_q;
    assign dig_sel     = dig_q;
    assign frame_start = fs_q;
    assign cur_digit   = cur_q;
endmodule

// File: tb/tb_seg_scan_reader.sv
// Bench for seg_scan_reader: two instances (dwell 3 / dwell 1) checked each cycle
// against a frame-position reference model under directed and random stimulus.
module tb_seg_scan_reader;
    logic        clk;
    logic        rst;
    logic        en;
    logic [27:0] din;

    logic [6:0] seg0, seg1;
    logic [3:0] dig0, dig1;
    logic       fs0, fs1;
    logic [2:0] cur0, cur1;

    int total = 0;
    int bad   = 0;
    int fs_cnt = 0;

    // Reference model: position within the frame, active flag and snapshot per instance.
    bit          m_act  [2];
    int          m_pos  [2];
    logic [27:0] m_snap [2];

    seg_scan_reader #(.NUM_DIGITS(4), .DWELL_CYCLES(3), .BLANK_CYCLES(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .seg_out(seg0), .dig_sel(dig0), .frame_start(fs0), .cur_digit(cur0)
    );

    seg_scan_reader #(.NUM_DIGITS(4), .DWELL_CYCLES(1), .BLANK_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .seg_out(seg1), .dig_sel(dig1), .frame_start(fs1), .cur_digit(cur1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_one(input int k, input logic [6:0] seg, input logic [3:0] dig,
                             input logic fs, input logic [2:0] cur);
        int         dwell, slot, digit, phase;
        logic [6:0] e_seg;
        logic [3:0] e_dig;
        logic       e_fs;
        logic [2:0] e_cur;
        dwell = (k == 0) ? 3 : 1;
        slot  = 1 + dwell;
        e_seg = 7'd0;
        e_dig = 4'd0;
        e_fs  = 1'b0;
        e_cur = 3'd0;
        if (m_act[k]) begin
            digit = m_pos[k] / slot;
            phase = m_pos[k] % slot;
            e_cur = 3'(digit);
            e_fs  = (m_pos[k] == 0);
            if (phase >= 1) begin
                e_seg = m_snap[k][7*digit +: 7];
                e_dig = 4'b0001 << digit;
            end
        end
        total++;
        assert (seg === e_seg) else begin bad++; $error("FAIL seg u%0d t=%0t got=%h exp=%h", k, $time, seg, e_seg); end
        total++;
        assert (dig === e_dig) else begin bad++; $error("FAIL dig_sel u%0d t=%0t got=%b exp=%b", k, $time, dig, e_dig); end
        total++;
        assert (fs === e_fs) else begin bad++; $error("FAIL frame_start u%0d t=%0t got=%b exp=%b", k, $time, fs, e_fs); end
        total++;
        assert (cur === e_cur) else begin bad++; $error("FAIL cur_digit u%0d t=%0t got=%0d exp=%0d", k, $time, cur, e_cur); end
        total++;
        assert ($countones(dig) <= 1) else begin bad++; $error("FAIL onehot u%0d t=%0t got=%b exp=<=1 hot", k, $time, dig); end
        total++;
        assert (!(dig == 4'd0 && seg != 7'd0)) else begin bad++; $error("FAIL seg_blank u%0d t=%0t got=%h exp=00", k, $time, seg); end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int period;
            period = 4 * (1 + ((k == 0) ? 3 : 1));
            if (!rst) begin
                m_act[k] = 0; m_pos[k] = 0; m_snap[k] = '0;
            end else if (!en) begin
                m_act[k] = 0; m_pos[k] = 0;
            end else if (!m_act[k]) begin
                m_act[k] = 1; m_pos[k] = 0; m_snap[k] = din;
            end else begin
                m_pos[k]++;
                if (m_pos[k] == period) begin
                    m_pos[k] = 0; m_snap[k] = din;
                end
            end
        end
        @(negedge clk);
        check_one(0, seg0, dig0, fs0, cur0);
        check_one(1, seg1, dig1, fs1, cur1);
        if (fs0) fs_cnt++;
    endtask

    task automatic wait_pos0(input int target, input string tag);
        int n;
        n = 0;
        while (!(m_act[0] && m_pos[0] == target) && n < 64) begin
            tick();
            n++;
        end
        total++;
        assert (n < 64) else begin bad++; $error("FAIL timeout_%s got=%0d cycles exp=<64", tag, n); end
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        din = {7'h7F, 7'h06, 7'h5B, 7'h3F};
        for (int i = 0; i < 2; i++) begin m_act[i] = 0; m_pos[i] = 0; m_snap[i] = '0; end
        repeat (3) tick();

        // Basic scan: three full frames of u0 from enable
        rst = 1'b1;
        en  = 1'b1;
        fs_cnt = 0;
        repeat (48) tick();
        total++;
        assert (fs_cnt == 3) else begin bad++; $error("FAIL fs_count got=%0d exp=3", fs_cnt); end

        // Mid-frame din change must wait for the next frame
        wait_pos0(9, "midframe");
        din[6:0] = 7'h66;
        repeat (32) tick();

        // Drop enable during digit 1 drive, then re-enable
        wait_pos0(5, "en_drop");
        en = 1'b0;
        tick();
        en = 1'b1;
        repeat (20) tick();

        // One-cycle reset during digit 2 drive with enable held
        wait_pos0(9, "rst_pulse");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (20) tick();

        // Random enable, data and occasional reset
        for (int i = 0; i < 10000; i++) begin
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 7) == 0) din = 28'($urandom);
            rst = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
